stream_demux_1to2: RTL and testbench
====================================

// Module: stream_demux_1to2
// PURPOSE
// - Routes one valid/ready data stream to one of two destination streams, per beat, by a sel bit.
// - Inverse of the 2:1 select used on the datapath: one producer, two consumers.
// - Example use: memory responses steered to fetch (dest 0) or load unit (dest 1).
// - Registered 2-entry elastic stage (main + skid): full throughput, no combinational in->out path.
// PARAMETERS
// - size   32   width of the signed data payload
// PORTS
// - clk         in   1      single clock; all state updates on rising edge
// - rst_n       in   1      asynchronous, active-low reset
// - in_valid    in   1      producer has a beat
// - in_sel      in   1      destination of the beat: 0 -> out0, 1 -> out1
// - in_data     in   size   signed payload
// - in_ready    out  1      stage can accept a beat (registered)
// - out0_valid  out  1      beat present for destination 0
// - out0_ready  in   1      destination 0 accepts
// - out1_valid  out  1      beat present for destination 1
// - out1_ready  in   1      destination 1 accepts
// - out_data    out  size   signed payload, shared by both outputs
// - occupancy   out  2      beats held: 0, 1 or 2
// BEHAVIOUR
// - Reset (async, rst_n=0): main_v=0, skid_v=0, sel/data regs=0; in_ready=1, out0_valid=out1_valid=0,
//   out_data=0, occupancy=0. Beats in flight at reset are discarded; no partial state survives.
// - Transfer in: in_fire = in_valid & in_ready. Transfer out: out_fire = main_v & (main_sel ? out1_ready : out0_ready).
// - out0_valid = main_v & ~main_sel; out1_valid = main_v & main_sel; out_data = main_data.
// - Ready of the non-selected destination is ignored; never both out*_valid high.
// - in_ready = ~skid_v (a flop output, no dependence on out*_ready in the same cycle).
// - States by (main_v, skid_v): EMPTY (0,0), ONE (1,0), FULL (1,1); (0,1) unreachable (assert).
// - EMPTY: in_fire -> main loads beat -> ONE. No fire -> stay.
// - ONE: in_fire & out_fire -> main loads new beat, stay ONE (throughput 1 beat/cycle).
//        in_fire & ~out_fire -> skid loads beat -> FULL. ~in_fire & out_fire -> EMPTY.
// - FULL: in_ready=0. out_fire -> skid moves to main, skid_v=0 -> ONE. Else hold all state.
// - Latency: beat accepted at edge N is visible on out*_valid after edge N (min 1 cycle). Order preserved
//   globally: a stalled dest-0 beat blocks a following dest-1 beat (head-of-line, by design).
// - While out*_valid is high and unaccepted, main_sel/main_data are stable (AXI-style stability).
// - Producer rule: in_sel/in_data stable while in_valid & ~in_ready; the block does not depend on it.
// - occupancy = main_v + skid_v.
// - Data is carried unmodified: no sign extension or truncation; width is exactly size.
// STRUCTURE
// - Shared package: DEST_0=1'b0, DEST_1=1'b1 select constants; occupancy width constant (2).
// - One natural sub-module: skid_reg_slice #(size+1) (main+skid, valid/ready both sides, carries {sel,data});
//   top level only decodes main_sel into out0/out1 valid and muxes the ready back.
// - Expected 120-200 lines total; no latches, no combinational loop ready->valid.
// TESTING
// - Reset: hold rst_n=0 while in_valid=1 -> in_ready=1, out0/1_valid=0, occupancy=0; release mid-stream -> no beat emitted.
// - Streaming: sel 0,1,0,1 data 10,-20,30,-40, both readys=1 -> out alternates dest 0/1 one beat/cycle, same order/values.
// - Back-pressure: out0_ready=0, send 5 (sel0), 6 (sel1), 7 -> occupancy 2, in_ready=0, 7 held off; out0_ready=1 -> 5 then 6 on out1 then 7.
// - Wrong-dest ready: beat sel=1 data 0x7FFFFFFF, out0_ready=1, out1_ready=0 -> out1_valid held, data stable, no fire.
// - Signed extremes: data 0x80000000 and 0xFFFFFFFF, size=32 -> bit-exact on out_data; repeat with size=8 build.
// - Async reset in FULL: assert rst_n mid-cycle -> all valids drop immediately, occupancy=0 before next edge.

Source files
------------

// File: rtl/stream_demux_1to2_pkg.sv
// Shared constants and types for the 1:2 stream demux and its elastic slice.
package stream_demux_1to2_pkg;

  localparam logic DEST_0 = 1'b0;
  localparam logic DEST_1 = 1'b1;
  localparam int   OCC_W  = 2;

  // Encoding is {skid_v, main_v}; 2'b10 would be a skid beat with no main beat.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } slice_state_e;

  function automatic logic [OCC_W-1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/stream_demux_1to2_skid_reg_slice.sv
// Two-entry registered elastic stage (main + skid). Ready toward the producer
// is a flop output, so there is no combinational path from i_ready to o_ready.
module skid_reg_slice
  import stream_demux_1to2_pkg::*;
#(
  parameter int W = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [W-1:0]     i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [W-1:0]     o_data,
  output logic [OCC_W-1:0] o_occupancy
);

  slice_state_e r_state;
  slice_state_e w_state_nxt;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         w_main_v;
  logic         w_skid_v;
  logic         w_in_fire;
  logic         w_out_fire;
  logic         w_ld_main_in;
  logic         w_ld_main_skid;
  logic         w_ld_skid;

  assign w_main_v    = r_state[0];
  assign w_skid_v    = r_state[1];
  assign o_ready     = ~w_skid_v;
  assign o_valid     = w_main_v;
  assign o_data      = r_main;
  assign o_occupancy = occ_count(w_main_v, w_skid_v);
  assign w_in_fire   = i_valid & ~w_skid_v;
  assign w_out_fire  = w_main_v & i_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_ld_main_in = 1'b1;
          w_state_nxt  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_ld_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_ld_skid   = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_ld_main_skid = 1'b1;
          w_state_nxt    = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main <= i_data;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= i_data;
      end
    end
  end

  a_no_orphan_skid : assert property (@(posedge clk) disable iff (!rst_n)
    r_state inside {ST_EMPTY, ST_ONE, ST_FULL});

endmodule

// File: rtl/stream_demux_1to2.sv
// 1:2 valid/ready demux: one registered elastic slice carries {sel, data};
// main_sel decodes which destination sees valid and whose ready is used.
module stream_demux_1to2
  import stream_demux_1to2_pkg::*;
#(
  parameter int size = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_sel,
  input  logic signed [size-1:0] in_data,
  output logic                   in_ready,
  output logic                   out0_valid,
  input  logic                   out0_ready,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic signed [size-1:0] out_data,
  output logic [OCC_W-1:0]       occupancy
);

  logic          w_main_v;
  logic          w_out_ready;
  logic [size:0] w_main;
  logic          w_main_sel;

  skid_reg_slice #(
    .W (size + 1)
  ) u_slice (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (in_valid),
    .o_ready     (in_ready),
    .i_data      ({in_sel, in_data}),
    .o_valid     (w_main_v),
    .i_ready     (w_out_ready),
    .o_data      (w_main),
    .o_occupancy (occupancy)
  );

  assign w_main_sel = w_main[size];
  assign out_data   = w_main[size-1:0];
  assign out0_valid = w_main_v & (w_main_sel == DEST_0);
  assign out1_valid = w_main_v & (w_main_sel == DEST_1);
  // Only the selected destination's ready can retire the head beat.
  assign w_out_ready = (w_main_sel == DEST_1) ? out1_ready : out0_ready;

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Scoreboard bench for stream_demux_1to2 (size=32 main instance, size=8 side instance).
module tb_stream_demux_1to2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid, in_sel, in_ready;
  logic signed [31:0] in_data, out_data;
  logic               out0_valid, out0_ready, out1_valid, out1_ready;
  logic [1:0]         occupancy;

  logic              in_valid8, in_sel8, in_ready8;
  logic signed [7:0] in_data8, out_data8;
  logic              out0_valid8, out1_valid8;
  logic [1:0]        occupancy8;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [32:0] sb[$];
  logic [32:0] exp_beat;

  always #5 clk = ~clk;

  stream_demux_1to2 #(.size(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
    .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out_data(out_data), .occupancy(occupancy)
  );

  stream_demux_1to2 #(.size(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_sel(in_sel8), .in_data(in_data8), .in_ready(in_ready8),
    .out0_valid(out0_valid8), .out0_ready(1'b1),
    .out1_valid(out1_valid8), .out1_ready(1'b1),
    .out_data(out_data8), .occupancy(occupancy8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every output fire, push on every input fire.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (out0_valid && out1_valid) check("both_valid", 32'd1, 32'd0);
      if ((out0_valid && out0_ready) || (out1_valid && out1_ready)) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          exp_beat = sb.pop_front();
          check("out_dest", {31'd0, out1_valid}, {31'd0, exp_beat[32]});
          check("out_data", out_data, exp_beat[31:0]);
        end
      end
      if (in_valid && in_ready) sb.push_back({in_sel, in_data});
    end
  end

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send(input logic sel, input logic [31:0] data);
    logic acc;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    for (int i = 0; i < 50; i++) begin
      acc = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    int t0;
    rst_n = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'sd123;
    out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid8 = 1'b0; in_sel8 = 1'b0; in_data8 = '0;

    // Reset held while the producer offers a beat
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    check("rst_occupancy", {30'd0, occupancy}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_valid", {30'd0, out1_valid, out0_valid}, 32'd0);
    check("post_rst_occ", {30'd0, occupancy}, 32'd0);

    // Back-to-back streaming alternating destinations
    t0 = cyc;
    send(1'b0, 32'd10);
    send(1'b1, -32'sd20);
    send(1'b0, 32'd30);
    send(1'b1, -32'sd40);
    check("stream_cycles", cyc - t0, 32'd4);
    drain();

    // Back-pressure on dest 0 fills both entries
    out0_ready = 1'b0;
    send(1'b0, 32'd5);
    send(1'b1, 32'd6);
    check("bp_occupancy", {30'd0, occupancy}, 32'd2);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_head_data", out_data, 32'd5);
    fork
      send(1'b0, 32'd7);
      begin
        repeat (3) @(negedge clk);
        check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_occ", {30'd0, occupancy}, 32'd2);
        out0_ready = 1'b1;
      end
    join
    drain();

    // Ready from the non-selected destination must not retire the beat
    out0_ready = 1'b1; out1_ready = 1'b0;
    send(1'b1, 32'h7FFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      check("wd_out1_valid", {31'd0, out1_valid}, 32'd1);
      check("wd_out0_valid", {31'd0, out0_valid}, 32'd0);
      check("wd_data_stable", out_data, 32'h7FFF_FFFF);
      @(negedge clk);
    end
    out1_ready = 1'b1;
    drain();

    // Signed extremes, 32-bit
    send(1'b0, 32'h8000_0000);
    send(1'b1, 32'hFFFF_FFFF);
    drain();

    // Signed extremes, 8-bit instance
    in_valid8 = 1'b1; in_sel8 = 1'b0; in_data8 = 8'sh80;
    @(negedge clk);
    check("w8_out0_valid", {31'd0, out0_valid8}, 32'd1);
    check("w8_data_80", {24'd0, $unsigned(out_data8)}, 32'h80);
    in_sel8 = 1'b1; in_data8 = 8'shFF;
    @(negedge clk);
    in_valid8 = 1'b0;
    check("w8_out1_valid", {31'd0, out1_valid8}, 32'd1);
    check("w8_data_ff", {24'd0, $unsigned(out_data8)}, 32'hFF);
    @(negedge clk);
    check("w8_occ_empty", {30'd0, occupancy8}, 32'd0);

    // Asynchronous reset while FULL
    out0_ready = 1'b0; out1_ready = 1'b0;
    send(1'b0, 32'd1);
    send(1'b0, 32'd2);
    check("full_occ", {30'd0, occupancy}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid", {30'd0, out1_valid, out0_valid}, 32'd0);
    check("areset_occ", {30'd0, occupancy}, 32'd0);
    check("areset_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("after_areset_occ", {30'd0, occupancy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
